mem_bus_responder: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/mem_bus_responder_ram.sv | 49 ++++
 rtl/mem_bus_responder.sv | 90 +++++++++
 tb/tb_mem_bus_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants for the multiplexed-bus memory responder:
// FSM encoding, default widths and the Rw line encoding.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ADDR  = 2'b01;
    localparam logic [1:0] ST_DRIVE = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port synchronous RAM with a programming/bus write mux and a
// registered read-before-write output; the programming write always wins.
module ram_sp_sync #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              bus_we_i,
    input  logic [ADDR_W-1:0] bus_waddr_i,
    input  logic [DATA_W-1:0] bus_wdata_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        we    = prog_we_i | bus_we_i;
        waddr = prog_we_i ? prog_addr_i : bus_waddr_i;
        wdata = prog_we_i ? prog_data_i : bus_wdata_i;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only loads on a read, so read data holds between strobes.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the ALE/En/Rw multiplexed bus: address latch,
// read/write FSM, collision flag, and a RAM shared with a programming port.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ALE,
    input  logic              En,
    input  logic              Rw,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [ADDR_W-1:0] addr_q,
    output logic              coll_err
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic              oe_q, oe_d;
    logic              coll_q, coll_d;
    logic              is_read, has_addr;
    logic              bus_we, ram_re;
    logic [ADDR_W-1:0] raddr;

    always_comb begin
        is_read  = (Rw == RW_READ);
        has_addr = (state_q != ST_IDLE);
        // A write needs a held address; with ALE the bus carries an address, not data.
        bus_we   = !rst && !ALE && En && !is_read && has_addr;
        ram_re   = !rst && En && is_read && (ALE || has_addr);
        raddr    = ALE ? bus_in[ADDR_W-1:0] : addr_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        coll_d  = coll_q | (bus_we & prog_we);
        if (ALE) begin
            addr_d  = bus_in[ADDR_W-1:0];
            state_d = (En && is_read) ? ST_DRIVE : ST_ADDR;
            oe_d    = En && is_read;
        end else if (En && has_addr) begin
            state_d = is_read ? ST_DRIVE : ST_ADDR;
            oe_d    = is_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            oe_q    <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            coll_q  <= coll_d;
        end
    end

    ram_sp_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk         (clk),
        .srst        (rst),
        .bus_we_i    (bus_we & ~prog_we),
        .bus_waddr_i (addr_q),
        .bus_wdata_i (bus_in),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .re_i        (ram_re),
        .raddr_i     (raddr),
        .rdata_o     (bus_out)
    );

    assign bus_oe   = oe_q;
    assign coll_err = coll_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scenario bench for mem_bus_responder: read data expectations are queued
// when a read strobe is driven and compared when the data appears.
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       rst, ale, en, rw, prog_we;
    logic [7:0] bus_in, prog_addr, prog_data;
    logic [7:0] bus_out, addr_q;
    logic       bus_oe, coll_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    always #5 clk = ~clk;

    mem_bus_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ALE       (ale),
        .En        (en),
        .Rw        (rw),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .addr_q    (addr_q),
        .coll_err  (coll_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ale = 0; en = 0; rw = 1; bus_in = 8'h00; prog_we = 0;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 0;
    endtask

    task automatic drive_ale(input logic [7:0] a, input logic r);
        ale = 1; en = 0; rw = r; bus_in = a;
        tick();
        ale = 0; rw = 1;
    endtask

    task automatic read_strobe(input logic [7:0] expected);
        en = 1; rw = 1;
        exp_q.push_back(expected);
        tick();
        en = 0;
        exp_v = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1; idle_bus(); prog_addr = 0; prog_data = 0;
        tick(); tick();
        checks += 4;
        if (addr_q !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", addr_q); end
        if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out got=%h exp=00", bus_out); end
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", bus_oe); end
        if (coll_err !== 1'b0) begin errors++; $display("FAIL reset_coll got=%b exp=0", coll_err); end
        rst = 0;
        $display("reset done");
    endtask

    task automatic test_read();
        prog_write(8'h10, 8'hA5);
        drive_ale(8'h10, 1'b1);
        checks += 2;
        if (addr_q !== 8'h10) begin errors++; $display("FAIL read_addr got=%h exp=10", addr_q); end
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL read_oe_pre got=%b exp=0", bus_oe); end
        read_strobe(8'hA5);
        checks += 2;
        if (bus_out !== exp_v) begin errors++; $display("FAIL read_data got=%h exp=%h", bus_out, exp_v); end
        if (bus_oe !== 1'b1) begin errors++; $display("FAIL read_oe got=%b exp=1", bus_oe); end
        tick(); tick(); tick();
        checks += 2;
        if (bus_out !== 8'hA5) begin errors++; $display("FAIL read_hold got=%h exp=a5", bus_out); end
        if (bus_oe !== 1'b1) begin errors++; $display("FAIL read_hold_oe got=%b exp=1", bus_oe); end
        drive_ale(8'h00, 1'b1);
        checks++;
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL read_release got=%b exp=0", bus_oe); end
        $display("read: addr=10 data=%h oe=%b", exp_v, bus_oe);
    endtask

    task automatic test_write_read();
        drive_ale(8'h20, 1'b0);
        checks++;
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL wr_oe_ale got=%b exp=0", bus_oe); end
        en = 1; rw = 0; bus_in = 8'h3C;
        tick();
        en = 0; rw = 1;
        checks++;
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL wr_oe_data got=%b exp=0", bus_oe); end
        drive_ale(8'h20, 1'b1);
        read_strobe(8'h3C);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL wr_readback got=%h exp=%h", bus_out, exp_v); end
        $display("write/read: addr=20 data=%h", bus_out);
    endtask

    task automatic test_bypass();
        prog_write(8'h07, 8'h5A);
        ale = 1; en = 1; rw = 1; bus_in = 8'h07;
        exp_q.push_back(8'h5A);
        tick();
        idle_bus();
        exp_v = exp_q.pop_front();
        checks += 3;
        if (addr_q !== 8'h07) begin errors++; $display("FAIL bypass_addr got=%h exp=07", addr_q); end
        if (bus_out !== exp_v) begin errors++; $display("FAIL bypass_data got=%h exp=%h", bus_out, exp_v); end
        if (bus_oe !== 1'b1) begin errors++; $display("FAIL bypass_oe got=%b exp=1", bus_oe); end
        // ALE with a write strobe: address only, RAM[0x20] must keep 0x3C
        ale = 1; en = 1; rw = 0; bus_in = 8'h20;
        tick();
        idle_bus();
        checks += 2;
        if (addr_q !== 8'h20) begin errors++; $display("FAIL alewr_addr got=%h exp=20", addr_q); end
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL alewr_oe got=%b exp=0", bus_oe); end
        read_strobe(8'h3C);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL alewr_nowrite got=%h exp=%h", bus_out, exp_v); end
        $display("bypass: addr=07 data=%h", 8'h5A);
    endtask

    task automatic test_collision();
        prog_write(8'h30, 8'h77);
        drive_ale(8'h30, 1'b0);
        en = 1; rw = 0; bus_in = 8'h11;
        prog_we = 1; prog_addr = 8'h31; prog_data = 8'h22;
        tick();
        idle_bus();
        checks++;
        if (coll_err !== 1'b1) begin errors++; $display("FAIL coll_set got=%b exp=1", coll_err); end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (coll_err !== 1'b1) begin errors++; $display("FAIL coll_sticky got=%b exp=1", coll_err); end
        drive_ale(8'h30, 1'b1);
        read_strobe(8'h77);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL coll_dropped got=%h exp=%h", bus_out, exp_v); end
        drive_ale(8'h31, 1'b1);
        read_strobe(8'h22);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL coll_prog got=%h exp=%h", bus_out, exp_v); end
        $display("collision: coll_err=%b", coll_err);
    endtask

    task automatic test_rst_drive();
        drive_ale(8'h10, 1'b1);
        read_strobe(8'hA5);
        checks++;
        if (bus_oe !== 1'b1) begin errors++; $display("FAIL rstd_drive got=%b exp=1", bus_oe); end
        rst = 1;
        tick();
        rst = 0;
        checks += 3;
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL rstd_oe got=%b exp=0", bus_oe); end
        if (addr_q !== 8'h00) begin errors++; $display("FAIL rstd_addr got=%h exp=00", addr_q); end
        if (coll_err !== 1'b0) begin errors++; $display("FAIL rstd_coll got=%b exp=0", coll_err); end
        en = 1; rw = 1;
        tick();
        en = 0;
        checks++;
        if (bus_oe !== 1'b0) begin errors++; $display("FAIL rstd_idle_read got=%b exp=0", bus_oe); end
        drive_ale(8'h20, 1'b1);
        read_strobe(8'h3C);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL rstd_ram_kept got=%h exp=%h", bus_out, exp_v); end
        $display("reset in drive: oe dropped, ram kept data=%h", bus_out);
    endtask

    task automatic test_reread();
        prog_write(8'h40, 8'h01);
        drive_ale(8'h40, 1'b1);
        read_strobe(8'h01);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL reread_first got=%h exp=%h", bus_out, exp_v); end
        prog_write(8'h40, 8'h02);
        checks++;
        if (bus_out !== 8'h01) begin errors++; $display("FAIL reread_hold got=%h exp=01", bus_out); end
        read_strobe(8'h02);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL reread_new got=%h exp=%h", bus_out, exp_v); end
        // Same-edge programming write and read: old contents come back
        prog_we = 1; prog_addr = 8'h40; prog_data = 8'h03;
        read_strobe(8'h02);
        prog_we = 0;
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL rbw_old got=%h exp=%h", bus_out, exp_v); end
        read_strobe(8'h03);
        checks++;
        if (bus_out !== exp_v) begin errors++; $display("FAIL rbw_new got=%h exp=%h", bus_out, exp_v); end
        $display("reread: data=%h", bus_out);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_bypass();
        test_collision();
        test_rst_drive();
        test_reread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
